// File: rtl/fifo_stream_reader_pkg.sv
// Shared sizing defaults and helpers for the FIFO read-side stream stage.
package fifo_stream_reader_pkg;

   localparam int DW_DEF        = 60;
   localparam int BUF_DEPTH_DEF = 3;
   localparam int FLW_DEF       = 16;
   localparam int BPW           = $clog2(BUF_DEPTH_DEF);
   localparam int BEAT_W        = 32;

   typedef logic [BEAT_W-1:0] beat_cnt_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying one data word plus a frame-last flag.
interface fifo_stream_reader_if
   import fifo_stream_reader_pkg::*;
#(
   parameter int DW = DW_DEF
);

   logic [DW-1:0] data;
   logic          valid;
   logic          ready;
   logic          last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Circular register buffer absorbing words already requested from the FIFO.
module stream_skid_buf
   import fifo_stream_reader_pkg::*;
#(
   parameter  int DW        = DW_DEF,
   parameter  int BUF_DEPTH = BUF_DEPTH_DEF,
   localparam int PW        = ptr_w(BUF_DEPTH),
   localparam int CW        = cnt_w(BUF_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   input  logic          clr,
   output logic [DW-1:0] head_data,
   output logic [CW-1:0] count
);

   logic [DW-1:0] mem [BUF_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Pointers wrap explicitly so non-power-of-2 depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is zeroed on reset so the stream data output starts at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      end else if (push && !clr) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the 256x60 FIFO into a valid/ready stream with frame-last marking
// and a running count of delivered beats.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF,
   parameter int FLW       = FLW_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic [DW-1:0]           fifo_dout,
   input  logic                    fifo_empty,
   output logic                    fifo_re,
   output logic                    fifo_clr,
   fifo_stream_reader_if.master    m,
   input  logic [FLW-1:0]          cfg_frame_len,
   output beat_cnt_t               beat_count
);

   localparam int CW = cnt_w(BUF_DEPTH);

   logic [CW-1:0]  count;
   logic [CW:0]    occupancy;
   logic           inflight;
   logic           pop;
   logic [FLW-1:0] frame_cnt;

   // Reads are reserved against buffered plus in-flight words, so m.ready never
   // reaches fifo_re and a requested word always has a free slot.
   assign occupancy = {1'b0, count} + (CW+1)'(inflight);
   assign fifo_re   = !fifo_empty && !clr && (occupancy < (CW+1)'(BUF_DEPTH));
   assign fifo_clr  = clr;

   assign m.valid = (count != '0);
   assign pop     = m.valid && m.ready;
   assign m.last  = m.valid && (cfg_frame_len != '0) &&
                    (frame_cnt == cfg_frame_len - FLW'(1));

   stream_skid_buf #(
      .DW        (DW),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (fifo_dout),
      .pop       (pop),
      .clr       (clr),
      .head_data (m.data),
      .count     (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) inflight <= 1'b0;
      else     inflight <= fifo_re;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      frame_cnt <= '0;
      else if (clr) frame_cnt <= '0;
      else if (pop) frame_cnt <= m.last ? '0 : frame_cnt + FLW'(1);
   end

   // Counts every accepted beat, including one taken in a flush cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      beat_count <= '0;
      else if (pop) beat_count <= beat_count + BEAT_W'(1);
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, queue-based scoreboard, vector table,
// directed corner sequences and a randomized run.
module tb_fifo_stream_reader;
   import fifo_stream_reader_pkg::*;

   localparam int DW = 60;
   localparam int BUF_DEPTH = 3;
   localparam int FLW = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           clr;
   logic [DW-1:0]  fifo_dout;
   logic           fifo_empty;
   logic           fifo_re;
   logic           fifo_clr;
   logic [FLW-1:0] cfg_frame_len;
   logic [31:0]    beat_count;
   logic           wr_en;
   logic [DW-1:0]  wr_data;

   fifo_stream_reader_if #(.DW(DW)) m_if ();

   fifo_stream_reader #(.DW(DW), .BUF_DEPTH(BUF_DEPTH), .FLW(FLW)) dut (
      .clk           (clk),
      .rst           (rst),
      .clr           (clr),
      .fifo_dout     (fifo_dout),
      .fifo_empty    (fifo_empty),
      .fifo_re       (fifo_re),
      .fifo_clr      (fifo_clr),
      .m             (m_if.master),
      .cfg_frame_len (cfg_frame_len),
      .beat_count    (beat_count)
   );

   always #5 clk = ~clk;

   // FIFO with a registered 1-cycle read latency
   logic [DW-1:0] fq[$];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fq.delete();
         fifo_empty <= 1'b1;
         fifo_dout  <= '0;
      end else if (fifo_clr) begin
         fq.delete();
         fifo_empty <= 1'b1;
      end else begin
         if (fifo_re && fq.size() > 0) fifo_dout <= fq.pop_front();
         if (wr_en) fq.push_back(wr_data);
         fifo_empty <= (fq.size() == 0);
      end
   end

   int            n_tests = 0;
   int            n_fail = 0;
   int            pop_total = 0;
   int            last_total = 0;
   int            re_total = 0;
   int            outstanding = 0;
   int            nbeat = 0;
   logic [31:0]   mcnt = '0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_pop_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: order of written words, beat count, frame position, occupancy.
   task automatic monitor();
      logic exp_last;
      int   len;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            mcnt = '0;
            nbeat = 0;
            outstanding = 0;
         end else begin
            len = int'(cfg_frame_len);
            chk("beat_count", beat_count, mcnt);
            if (fifo_empty || clr) chk("fifo_re_gated", fifo_re, 0);
            exp_last = m_if.valid && (len != 0) && ((nbeat % (len == 0 ? 1 : len)) == len - 1);
            chk("m_last", m_if.last, exp_last);
            if (exp_q.size() == 0) chk("m_valid_without_data", m_if.valid, 0);
            else if (m_if.valid)   chk("m_data", m_if.data, exp_q[0]);
            if (m_if.valid && m_if.ready) begin
               mcnt = mcnt + 1;
               nbeat++;
               pop_total++;
               if (m_if.last) last_total++;
               last_pop_data = m_if.data;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               outstanding--;
            end
            if (fifo_re) begin
               re_total++;
               outstanding++;
            end
            if (clr) begin
               exp_q.delete();
               nbeat = 0;
               outstanding = 0;
            end else if (wr_en) begin
               exp_q.push_back(wr_data);
            end
            chk("occupancy_le_depth", (outstanding <= BUF_DEPTH), 1);
         end
      end
   endtask

   task automatic flush(input int new_len);
      clr = 1'b1;
      wr_en = 1'b0;
      tick();
      clr = 1'b0;
      cfg_frame_len = FLW'(new_len);
   endtask

   function automatic logic [DW-1:0] rand_word();
      return {$urandom, $urandom};
   endfunction

   typedef struct {
      int nwords;
      int frame_len;
      int ready_mode;
      int exp_beats;
      int exp_lasts;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int p0, l0, r0, written;
      logic [31:0] b0;
      bit prev_clr;

      rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_data = '0;
      m_if.ready = 1'b0; cfg_frame_len = '0;
      fork monitor(); join_none

      vecs[0] = '{12, 4, 0, 12, 3};
      vecs[1] = '{12, 0, 0, 12, 0};
      vecs[2] = '{8,  0, 1, 8,  0};
      vecs[3] = '{10, 3, 1, 10, 3};
      vecs[4] = '{7,  1, 2, 7,  7};
      vecs[5] = '{9,  5, 2, 9,  1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", m_if.valid, 0);
      chk("rst_m_last", m_if.last, 0);
      chk("rst_m_data", m_if.data, 0);
      chk("rst_fifo_re", fifo_re, 0);
      chk("rst_beat_count", beat_count, 0);
      rst = 1'b0;
      tick();

      // Preload 0..9 while stalled, then stream them back-to-back
      for (int i = 0; i < 10; i++) begin
         wr_en = 1'b1; wr_data = DW'(i);
         tick();
      end
      wr_en = 1'b0;
      repeat (5) tick();
      m_if.ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t1_valid", m_if.valid, 1);
         chk("t1_data", m_if.data, i);
      end
      tick();
      chk("t1_beat_count", beat_count, 10);

      // Vector table: frame lengths and ready patterns
      for (int v = 0; v < 6; v++) begin
         flush(vecs[v].frame_len);
         p0 = pop_total; l0 = last_total; b0 = beat_count; written = 0;
         for (int c = 0; c < 600 && !(written == vecs[v].nwords && pop_total - p0 == vecs[v].nwords); c++) begin
            wr_en = (written < vecs[v].nwords);
            if (wr_en) begin
               wr_data = rand_word();
               written++;
            end
            case (vecs[v].ready_mode)
               0:       m_if.ready = 1'b1;
               1:       m_if.ready = (c % 2 == 0);
               default: m_if.ready = 1'($urandom_range(0, 1));
            endcase
            tick();
         end
         wr_en = 1'b0;
         m_if.ready = 1'b1;
         repeat (6) tick();
         chk("vec_beats", pop_total - p0, vecs[v].exp_beats);
         chk("vec_lasts", last_total - l0, vecs[v].exp_lasts);
         chk("vec_beat_count", beat_count - b0, vecs[v].exp_beats);
      end

      // Stalled consumer: only BUF_DEPTH reads are issued
      m_if.ready = 1'b0;
      flush(0);
      r0 = re_total; p0 = pop_total;
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; wr_data = rand_word();
         tick();
      end
      wr_en = 1'b0;
      repeat (8) tick();
      chk("t3_reads", re_total - r0, 3);
      chk("t3_fifo_re", fifo_re, 0);
      chk("t3_fifo_level", fq.size(), 17);
      m_if.ready = 1'b1;
      repeat (30) tick();
      chk("t3_drained", pop_total - p0, 20);

      // Flush with two buffered words and one in flight
      m_if.ready = 1'b0;
      flush(0);
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = rand_word();
         tick();
      end
      wr_en = 1'b0;
      repeat (8) tick();
      m_if.ready = 1'b1;
      tick();
      m_if.ready = 1'b0;
      tick();
      clr = 1'b1;
      @(negedge clk);
      chk("t5_re_in_clr", fifo_re, 0);
      chk("t5_valid_in_clr", m_if.valid, 1);
      @(posedge clk);
      #1;
      clr = 1'b0;
      @(negedge clk);
      chk("t5_valid_after", m_if.valid, 0);
      chk("t5_fifo_level", fq.size(), 0);
      chk("t5_fifo_empty", fifo_empty, 1);
      tick();
      p0 = pop_total;
      wr_en = 1'b1; wr_data = DW'(12'hABC); m_if.ready = 1'b1;
      tick();
      wr_en = 1'b0;
      repeat (8) tick();
      chk("t5_beats", pop_total - p0, 1);
      chk("t5_data", last_pop_data, 12'hABC);

      // Reset in the middle of a stream
      flush(0);
      m_if.ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = rand_word();
         tick();
      end
      rst = 1'b1; wr_en = 1'b0;
      #1;
      chk("t6_m_valid", m_if.valid, 0);
      chk("t6_m_last", m_if.last, 0);
      chk("t6_m_data", m_if.data, 0);
      chk("t6_fifo_re", fifo_re, 0);
      chk("t6_beat_count", beat_count, 0);
      tick();
      rst = 1'b0;
      wr_en = 1'b1; wr_data = DW'(60'h123456789ABCDEF);
      tick();
      wr_en = 1'b0;
      @(negedge clk);
      chk("t6_re_after_write", fifo_re, 1);
      chk("t6_valid_t", m_if.valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("t6_valid_t1", m_if.valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("t6_valid_t2", m_if.valid, 1);
      chk("t6_data_t2", m_if.data, 60'h123456789ABCDEF);
      tick();

      // Randomized traffic with occasional flushes
      flush($urandom_range(0, 6));
      prev_clr = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (prev_clr) cfg_frame_len = FLW'($urandom_range(0, 6));
         wr_en = (fq.size() < 200) && ($urandom_range(0, 99) < 55);
         wr_data = rand_word();
         m_if.ready = ($urandom_range(0, 99) < 70);
         clr = ($urandom_range(0, 127) == 0);
         prev_clr = clr;
         tick();
      end
      clr = 1'b0; wr_en = 1'b0; m_if.ready = 1'b1;
      for (int c = 0; c < 600 && (exp_q.size() != 0 || fq.size() != 0); c++) tick();
      repeat (4) tick();
      chk("rand_drain_model", exp_q.size(), 0);
      chk("rand_drain_outstanding", outstanding, 0);
      chk("rand_drain_valid", m_if.valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
